// File: rtl/keypad_scanner.sv
// ---------------------------------------------------------------------------
// keypad_scanner
//
// Row-scanning controller for a 4x4 matrix keypad. Drives one row low at a
// time, samples the synchronised columns once the row has settled, debounces
// a press, reports it as a one-cycle strobe plus 4-bit code, then waits for a
// debounced release before moving on to the next row.
//
// Parameters
//   SETTLE_CYCLES   : cycles a new row is driven before sampling (3..65535;
//                     must cover the 3-cycle column synchroniser path)
//   DEBOUNCE_CYCLES : consecutive stable cycles needed to accept a press
//                     and to accept a release (1..65535)
//
// Ports
//   clk         in   system clock, rising edge
//   rst         in   asynchronous active-high reset
//   col_data    in   [3:0] synchronised column levels, active-low
//   key_pressed in   high when col_data != 4'b1111
//   row_out     out  [3:0] row drive, active-low one-hot
//   key_code    out  [3:0] {row, col} of the last accepted key (sticky)
//   key_valid   out  one-cycle strobe marking a new key_code
//   key_held    out  high from acceptance until release is accepted
// ---------------------------------------------------------------------------
module keypad_scanner #(
  parameter int unsigned SETTLE_CYCLES   = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] col_data,
  input  logic       key_pressed,
  output logic [3:0] row_out,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
);

  typedef enum logic [2:0] {
    SCAN_DRIVE   = 3'd0,
    SAMPLE       = 3'd1,
    DEBOUNCE     = 3'd2,
    REPORT       = 3'd3,
    WAIT_RELEASE = 3'd4
  } state_t;

  // Terminal counts; full 16-bit equality so the counter never wraps.
  localparam logic [15:0] SETTLE_LAST = 16'(SETTLE_CYCLES - 1);
  localparam logic [15:0] DB_LAST     = 16'(DEBOUNCE_CYCLES - 1);

  state_t      state_q, state_d;
  logic [1:0]  row_q, row_d;
  logic [15:0] cnt_q, cnt_d;
  logic [3:0]  cap_q, cap_d;
  logic [3:0]  row_out_q, row_out_d;
  logic [3:0]  key_code_q, key_code_d;
  logic        key_valid_q, key_valid_d;
  logic        key_held_q, key_held_d;

  // Active-low one-hot drive pattern for a row index.
  function automatic logic [3:0] row_drive(input logic [1:0] r);
    return ~(4'b0001 << r);
  endfunction

  // Lowest-numbered low column wins, so multi-column presses report the
  // smallest column index. A captured value always has a zero bit, the
  // all-ones fallthrough is unreachable.
  function automatic logic [1:0] col_idx(input logic [3:0] c);
    logic [1:0] idx;
    if      (!c[0]) idx = 2'd0;
    else if (!c[1]) idx = 2'd1;
    else if (!c[2]) idx = 2'd2;
    else            idx = 2'd3;
    return idx;
  endfunction

  // Column pattern still matches the one captured at SAMPLE.
  logic press_stable;
  assign press_stable = key_pressed && (col_data == cap_q);

  // Next row, used by every path that gives up on the current row.
  logic [1:0] row_next;
  assign row_next = row_q + 2'd1;

  always_comb begin
    state_d     = state_q;
    row_d       = row_q;
    cnt_d       = cnt_q;
    cap_d       = cap_q;
    row_out_d   = row_out_q;
    key_code_d  = key_code_q;
    key_held_d  = key_held_q;
    key_valid_d = 1'b0;

    unique case (state_q)
      SCAN_DRIVE: begin
        if (cnt_q == SETTLE_LAST) begin
          state_d = SAMPLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end

      SAMPLE: begin
        if (key_pressed) begin
          cap_d   = col_data;
          cnt_d   = '0;
          state_d = DEBOUNCE;
        end else begin
          row_d     = row_next;
          row_out_d = row_drive(row_next);
          cnt_d     = '0;
          state_d   = SCAN_DRIVE;
        end
      end

      DEBOUNCE: begin
        if (press_stable) begin
          if (cnt_q == DB_LAST) begin
            // Outputs are registered: load them on entry so the strobe is
            // high exactly during the REPORT cycle.
            state_d     = REPORT;
            cnt_d       = '0;
            key_valid_d = 1'b1;
            key_held_d  = 1'b1;
            key_code_d  = {row_q, col_idx(cap_q)};
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end else begin
          // Bounce or release mid-debounce: drop it silently.
          row_d     = row_next;
          row_out_d = row_drive(row_next);
          cnt_d     = '0;
          state_d   = SCAN_DRIVE;
        end
      end

      REPORT: begin
        state_d = WAIT_RELEASE;
        cnt_d   = '0;
      end

      WAIT_RELEASE: begin
        if (key_pressed) begin
          cnt_d = '0;
        end else if (cnt_q == DB_LAST) begin
          key_held_d = 1'b0;
          row_d      = row_next;
          row_out_d  = row_drive(row_next);
          cnt_d      = '0;
          state_d    = SCAN_DRIVE;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end

      default: begin
        state_d   = SCAN_DRIVE;
        row_d     = 2'd0;
        row_out_d = row_drive(2'd0);
        cnt_d     = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= SCAN_DRIVE;
      row_q       <= 2'd0;
      cnt_q       <= '0;
      cap_q       <= 4'b1111;
      row_out_q   <= 4'b1110;
      key_code_q  <= 4'h0;
      key_valid_q <= 1'b0;
      key_held_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      row_q       <= row_d;
      cnt_q       <= cnt_d;
      cap_q       <= cap_d;
      row_out_q   <= row_out_d;
      key_code_q  <= key_code_d;
      key_valid_q <= key_valid_d;
      key_held_q  <= key_held_d;
    end
  end

  assign row_out   = row_out_q;
  assign key_code  = key_code_q;
  assign key_valid = key_valid_q;
  assign key_held  = key_held_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// ---------------------------------------------------------------------------
// tb_keypad_scanner
//
// Keypad matrix + 3-stage column synchroniser around the scanner. Each
// scenario starts from reset, so every event time follows from the timing
// rules with plain arithmetic: row r is sampled at cycle (S+1)*r+S, a stable
// press reports DB+1 cycles after its sample, a release is accepted DB cycles
// after the first of DB quiet cycles. A per-cycle expected output word is
// built from those event times and compared with the DUT every cycle.
// ---------------------------------------------------------------------------
module tb_keypad_scanner;

  localparam int S  = 4;
  localparam int DB = 8;
  localparam int P  = S + 1;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] col_data;
  logic       key_pressed;
  logic [3:0] row_out, key_code;
  logic       key_valid, key_held;

  logic [15:0] mat = '0;          // bit r*4+c = key (row r, col c) down
  logic [3:0]  col_in, s1, s2;

  keypad_scanner #(.SETTLE_CYCLES(S), .DEBOUNCE_CYCLES(DB)) dut (
    .clk(clk), .rst(rst), .col_data(col_data), .key_pressed(key_pressed),
    .row_out(row_out), .key_code(key_code), .key_valid(key_valid),
    .key_held(key_held)
  );

  always #5 clk = ~clk;

  // Keypad: a column reads low if a pressed key connects it to a driven row.
  always_comb begin
    col_in = 4'hF;
    for (int r = 0; r < 4; r++)
      if (!row_out[r]) col_in = col_in & ~mat[r*4 +: 4];
  end

  always @(posedge clk) begin
    s1       <= col_in;
    s2       <= s1;
    col_data <= s2;
  end
  assign key_pressed = (col_data != 4'hF);

  // ---- scoreboard state ----
  int checks = 0;
  int fails  = 0;
  int cur_n  = 0;

  logic [15:0] sched [1024];
  int sc_kind;     // 0 idle, 1 accepted press, 2 abandoned press
  int sc_R, sc_t, sc_rep, sc_resume, sc_len;
  logic [3:0] sc_code;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cur_n, got, exp);
    end
  endtask

  function automatic int lowcol(input logic [3:0] m);
    int lc = 0;
    for (int c = 3; c >= 0; c--) if (m[c]) lc = c;
    return lc;
  endfunction

  // {row_out, key_valid, key_held, key_code} expected in cycle n.
  function automatic logic [9:0] exp_at(input int n);
    int r;
    logic [3:0] ro, c;
    logic v, h;
    if (sc_kind == 0 || n <= sc_t) r = (n / P) % 4;
    else if (n < sc_resume)        r = sc_R;
    else                           r = (sc_R + 1 + (n - sc_resume) / P) % 4;
    ro    = 4'hF;
    ro[r] = 1'b0;
    v = (sc_kind == 1) && (n == sc_rep);
    h = (sc_kind == 1) && (n >= sc_rep) && (n < sc_resume);
    c = (sc_kind == 1 && n >= sc_rep) ? sc_code : 4'h0;
    return {ro, v, h, c};
  endfunction

  task automatic clear_sched();
    for (int i = 0; i < 1024; i++) sched[i] = '0;
  endtask

  task automatic plan_idle();
    clear_sched();
    sc_kind = 0;
    sc_len  = 3 * 4 * P;
  endtask

  // Key(s) mask m in row r held for `hold` cycles past the report, then
  // released through nb short bounces.
  task automatic plan_accept(input int r, input logic [3:0] m, input int hold, input int nb);
    int h_end, p, g, b, lm;
    clear_sched();
    sc_kind = 1;
    sc_R    = r;
    sc_t    = P * r + S;
    sc_rep  = sc_t + DB + 1;
    sc_code = 4'(r * 4 + lowcol(m));
    h_end   = sc_rep + hold;
    for (int i = 0; i < h_end; i++) sched[i] = 16'(m) << (4 * r);
    p  = h_end;
    lm = h_end - 1;
    for (int j = 0; j < nb; j++) begin
      g = $urandom_range(1, DB - 2);
      b = $urandom_range(1, 3);
      p += g;
      for (int i = 0; i < b; i++) sched[p + i] = 16'(m) << (4 * r);
      lm = p + b - 1;
      p += b;
    end
    // Synchroniser delay 3: first quiet col_data cycle is lm+4.
    sc_resume = lm + 4 + DB;
    sc_len    = sc_resume + 2 * 4 * P;
  endtask

  // Press m in row r; col_data first deviates (to m2) k cycles after sample,
  // toggling every 3 cycles for a while, then everything released.
  task automatic plan_abandon(input int r, input logic [3:0] m, input logic [3:0] m2, input int k);
    int f;
    clear_sched();
    sc_kind   = 2;
    sc_R      = r;
    sc_t      = P * r + S;
    sc_resume = sc_t + k + 1;
    f         = sc_t + k - 3;
    for (int i = 0; i < f; i++) sched[i] = 16'(m) << (4 * r);
    for (int j = 0; j < 9; j++)
      sched[f + j] = 16'(((j / 3) % 2 == 0) ? m2 : m) << (4 * r);
    sc_len = sc_resume + 2 * 4 * P;
  endtask

  // Reset, then step cycle by cycle comparing against the plan. If rst_at
  // is reached, reset is asserted mid-cycle and must take effect at once.
  task automatic run_plan(input string tag, input int rst_at);
    bit stop = 0;
    rst = 1'b1;
    mat = sched[0];
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int n = 0; n < sc_len && !stop; n++) begin
      cur_n = n;
      if (n == rst_at) begin
        rst = 1'b1;
        #1;
        chk({tag, "_rst"}, 32'({row_out, key_valid, key_held, key_code}),
            32'({4'b1110, 1'b0, 1'b0, 4'h0}));
        stop = 1;
      end else begin
        chk(tag, 32'({row_out, key_valid, key_held, key_code}), 32'(exp_at(n)));
        mat = sched[n];
        @(posedge clk);
        @(negedge clk);
      end
    end
    mat = '0;
  endtask

  initial begin
    int r, k;
    logic [3:0] m;

    plan_idle();                         run_plan("idle", -1);
    plan_accept(2, 4'b0010, 40, 0);      run_plan("press_r2c1", -1);
    plan_abandon(2, 4'b0010, 4'b0000, 1); run_plan("bounce", -1);
    plan_accept(1, 4'(2 ** $urandom_range(0, 3)), 200, 2); run_plan("long_hold", -1);
    plan_accept(0, 4'b1100, 20, 1);      run_plan("multi", -1);
    plan_accept(3, 4'b1000, 20, 1);      run_plan("wrap", -1);

    // Reset during DEBOUNCE, then a clean restart from row 0.
    plan_accept($urandom_range(0, 3), 4'($urandom_range(1, 15)), 30, 1);
    run_plan("rst_db", sc_t + $urandom_range(1, DB));
    plan_idle();                         run_plan("post_rst_db", -1);

    // Reset during WAIT_RELEASE.
    plan_accept($urandom_range(0, 3), 4'($urandom_range(1, 15)), 30, 1);
    run_plan("rst_wr", $urandom_range(sc_rep + 1, sc_resume - 1));
    plan_idle();                         run_plan("post_rst_wr", -1);

    for (int it = 0; it < 12; it++) begin
      r = $urandom_range(0, 3);
      m = 4'($urandom_range(1, 15));
      if ($urandom_range(0, 1) == 0) begin
        plan_accept(r, m, $urandom_range(5, 60), $urandom_range(0, 3));
        run_plan("rnd_accept", -1);
      end else begin
        k = $urandom_range(1, DB);
        plan_abandon(r, m, m ^ 4'($urandom_range(1, 15)), k);
        run_plan("rnd_abandon", -1);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule

// File: doc/keypad_scanner.md
# keypad_scanner

Row-scanning controller for the 4x4 matrix keypad, directly downstream of the column synchroniser. It consumes the synchronised `col_data` / `key_pressed` pair and drives the keypad rows one at a time (active-low). It debounces a detected press, emits a one-cycle `key_valid` strobe with a 4-bit key code, then waits for a debounced release before resuming the scan. Its `key_code` / `key_valid` outputs feed the application logic.

## Interface
- `SETTLE_CYCLES`, default 4: cycles a newly driven row is held before sampling.
  - Must be ≥ 3 to cover the synchroniser's 3-cycle `col_in` → `col_data` path.
  - Legal range 3..65535.
- `DEBOUNCE_CYCLES`, default 16: consecutive stable cycles required for both press acceptance and release acceptance. Legal range 1..65535.

- `clk`  in  1: system clock; all state changes on the rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `col_data`  in  4: synchronised column levels, active-low (bit n = column n).
- `key_pressed`  in  1: high when `col_data != 4'b1111`.
- `row_out`  out  4: row drive, active-low one-hot (bit r low = row r driven).
- `key_code`  out  4: `{row[1:0], col[1:0]}` of the last accepted key; holds until the next accepted key.
- `key_valid`  out  1: one-cycle strobe marking a new `key_code`.
- `key_held`  out  1: high from acceptance until release is accepted.

## Operation
- All outputs are registered. Internal state: `state`, `row` (2 bits), 16-bit counter `cnt`, 4-bit captured column `cap`.
- Reset values:
  - `row_out=4'b1110`, `row=0`
  - `key_code=4'h0`, `key_valid=0`, `key_held=0`
  - `state=SCAN_DRIVE`, `cnt=0`, `cap=4'b1111`
- SCAN_DRIVE: `row_out` drives `row`. `cnt` increments each cycle. When `cnt==SETTLE_CYCLES-1`: go to SAMPLE, clear `cnt`.
- SAMPLE (1 cycle):
  - If `key_pressed`: `cap<=col_data`, go to DEBOUNCE, `cnt=0`.
  - Otherwise: `row<=row+1` (3 wraps to 0), update `row_out`, go to SCAN_DRIVE.
- DEBOUNCE: row drive unchanged.
  - If `key_pressed && col_data==cap`: `cnt` increments. At `cnt==DEBOUNCE_CYCLES-1`, go to REPORT.
  - Any mismatch or `key_pressed==0`: abandon, advance to the next row, go to SCAN_DRIVE. No report is made.
- REPORT (1 cycle): `key_valid=1`, `key_held=1`, and `key_code={row, colidx(cap)}`. Then go to WAIT_RELEASE with `cnt=0`.
- colidx: index of the lowest-numbered zero bit in `cap` (priority bit0 > bit1 > bit2 > bit3). Multi-column presses therefore report the lowest column.
- WAIT_RELEASE: row drive unchanged, `key_held=1`.
  - `cnt` increments while `key_pressed==0`; any cycle with `key_pressed==1` clears `cnt`.
  - At `cnt==DEBOUNCE_CYCLES-1` (with `key_pressed==0`): `key_held<=0`, advance to the next row, go to SCAN_DRIVE.
- A held key never generates a second `key_valid`; a new strobe requires release plus a new press.
- `key_valid` is 0 in every state except REPORT.

## Timing
- Idle scan: each row is driven for `SETTLE_CYCLES+1` cycles. Full frame = `4*(SETTLE_CYCLES+1)` cycles (20 at defaults).
- Row change is visible on `row_out` in the cycle after SAMPLE.
- Press latency: SAMPLE at cycle t with `key_pressed=1`. With stable input, `key_valid` is high exactly in cycle `t+DEBOUNCE_CYCLES+1`.
- Release: the first cycle of `DEBOUNCE_CYCLES` consecutive zeros is cycle u. `key_held` falls at `u+DEBOUNCE_CYCLES`, and the next row is driven from that same cycle.
- Reset asserted in any state returns all outputs to reset values immediately (asynchronously). There is no `key_valid` glitch, and a press in progress is discarded.
- First SAMPLE after reset deassertion occurs `SETTLE_CYCLES` cycles later, on row 0.
- Counter compare uses full 16-bit equality; `cnt` never wraps.

## Test plan
- **Idle scan** (no key, `SETTLE=4`): `row_out` steps 1110→1101→1011→0111→1110, each held 5 cycles. `key_valid` never asserts.
- **Clean press** (row 2, column 1, `DEBOUNCE=8`; keypad model plus column synchroniser): exactly one `key_valid` pulse with `key_code=4'h9`, 9 cycles after SAMPLE. `key_held=1` until release.
- **Bounce:** `col_data` toggles 1101↔1111 every 3 cycles during DEBOUNCE. No `key_valid`; scanning resumes on row 3.
- **Long hold and release:** hold 200 cycles, then release with 2 bounce cycles. A single `key_valid`. `key_held` falls 8 cycles after the last bounce. The next row is driven.
- **Multi-key:** row 0, columns 2 and 3 low → `key_code=4'h2`. Row 3, column 3 → `4'hF` (wrap and max code).
- **Mid-operation reset:** assert `rst` during DEBOUNCE and during WAIT_RELEASE. Outputs return to reset values immediately; `key_code=0`; scan restarts on row 0.
